decode_stage_p: RTL and testbench

- Parametrised successor of the fetch-to-decode pipeline stage.
- Latches fetched instruction fields and reads a parametrised register file.
- Resolves operands through E/M/W forwarding and stalls on load-use hazards, including M-stage loads whose data is not yet ready.
- Sits between fetch and execute using the valid/allow_in handshake.

---
 rtl/decode_stage_p_pkg.sv | 29 ++
 rtl/decode_regfile.sv | 30 +++
 rtl/decode_stage_p.sv | 164 ++++++++++++++++
 tb/tb_decode_stage_p.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_p_pkg.sv
// Shared decode definitions: opcodes, instruction-type codes and source-usage helpers.
package decode_stage_p_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] TYPER = 3'd0;
  localparam logic [2:0] TYPEI = 3'd1;
  localparam logic [2:0] TYPES = 3'd2;
  localparam logic [2:0] TYPEB = 3'd3;
  localparam logic [2:0] TYPEU = 3'd4;
  localparam logic [2:0] TYPEJ = 3'd5;

  function automatic logic uses_rs1(input logic [2:0] t);
    return t inside {TYPER, TYPEI, TYPES, TYPEB};
  endfunction

  function automatic logic uses_rs2(input logic [2:0] t);
    return t inside {TYPER, TYPES, TYPEB};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two combinational read ports, one write port, x0 hardwired to zero.
module decode_regfile #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_NUM = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(REG_NUM)-1:0] raddr1_i,
  input  logic [$clog2(REG_NUM)-1:0] raddr2_i,
  output logic [XLEN-1:0]            rdata1_o,
  output logic [XLEN-1:0]            rdata2_o,
  input  logic                       we_i,
  input  logic [$clog2(REG_NUM)-1:0] waddr_i,
  input  logic [XLEN-1:0]            wdata_i
);

  logic [XLEN-1:0] mem_q [REG_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage_p.sv
// Decode pipeline stage: latches fetch fields, reads registers, forwards E/M/W results, stalls on load-use.
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.
module decode_stage_p
  import decode_stage_p_pkg::*;
#(
  parameter int unsigned    XLEN         = 32,
  parameter int unsigned    REG_NUM      = 32,
  parameter logic [XLEN-1:0] COMMIT_BASE  = XLEN'(32'h80000000),
  parameter logic [XLEN-1:0] COMMIT_LIMIT = XLEN'(32'h87ffffff)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       f_to_d_valid,
  output logic                       d_allow_in,
  input  logic                       e_allow_in,
  output logic                       d_to_e_valid,
  input  logic [XLEN-1:0]            f_pc,
  input  logic [XLEN-1:0]            f_default_pc,
  input  logic [31:0]                f_instr,
  input  logic [6:0]                 f_opcode,
  input  logic [9:0]                 f_funct,
  input  logic [$clog2(REG_NUM)-1:0] f_rd,
  input  logic [$clog2(REG_NUM)-1:0] f_rs1,
  input  logic [$clog2(REG_NUM)-1:0] f_rs2,
  input  logic [XLEN-1:0]            f_imm,
  input  logic [2:0]                 f_instr_type,
  input  logic                       e_valid,
  input  logic                       e_wen,
  input  logic                       e_is_load,
  input  logic [$clog2(REG_NUM)-1:0] e_rd,
  input  logic [XLEN-1:0]            e_data,
  input  logic                       m_valid,
  input  logic                       m_wen,
  input  logic                       m_data_ok,
  input  logic [$clog2(REG_NUM)-1:0] m_rd,
  input  logic [XLEN-1:0]            m_data,
  input  logic                       w_valid,
  input  logic                       w_wen,
  input  logic [$clog2(REG_NUM)-1:0] w_rd,
  input  logic [XLEN-1:0]            w_data,
  output logic [XLEN-1:0]            D_pc,
  output logic [XLEN-1:0]            D_default_pc,
  output logic [XLEN-1:0]            D_imm,
  output logic [31:0]                D_instr,
  output logic [6:0]                 D_opcode,
  output logic [9:0]                 D_funct,
  output logic [2:0]                 D_instr_type,
  output logic [$clog2(REG_NUM)-1:0] D_rd,
  output logic [$clog2(REG_NUM)-1:0] D_rs1,
  output logic [$clog2(REG_NUM)-1:0] D_rs2,
  output logic                       D_commit,
  output logic [XLEN-1:0]            d_val1,
  output logic [XLEN-1:0]            d_val2
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  localparam int unsigned RW = $clog2(REG_NUM);

  logic            d_valid_q;
  logic            stall;
  logic            capture;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;

  decode_regfile #(.XLEN(XLEN), .REG_NUM(REG_NUM)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (D_rs1),
    .raddr2_i (D_rs2),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (w_valid && w_wen),
    .waddr_i  (w_rd),
    .wdata_i  (w_data)
  );

  // Per-source hazard detection and forwarding mux (E non-load > M ready > W > register file).
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [RW-1:0]   rs;
    logic            live;
    logic            e_hit;
    logic            m_hit;
    logic            w_hit;
    logic            stall_c;
    logic [XLEN-1:0] val;

    assign rs      = (s == 0) ? D_rs1 : D_rs2;
    assign live    = ((s == 0) ? uses_rs1(D_instr_type) : uses_rs2(D_instr_type)) && (rs != '0);
    assign e_hit   = e_valid && e_wen && (e_rd == rs) && (e_rd != '0);
    assign m_hit   = m_valid && m_wen && (m_rd == rs) && (m_rd != '0);
    assign w_hit   = w_valid && w_wen && (w_rd == rs) && (w_rd != '0);
    assign stall_c = live && ((e_hit && e_is_load) || (m_hit && !m_data_ok));

    always_comb begin
      val = '0;
      if (live) begin
        if (e_hit && !e_is_load)    val = e_data;
        else if (m_hit && m_data_ok) val = m_data;
        else if (w_hit)              val = w_data;
        else                         val = (s == 0) ? rf_rdata1 : rf_rdata2;
      end
    end
  end

  assign d_val1       = g_src[0].val;
  assign d_val2       = g_src[1].val;
  assign stall        = g_src[0].stall_c || g_src[1].stall_c;
  assign d_allow_in   = !d_valid_q || (!stall && e_allow_in);
  assign d_to_e_valid = d_valid_q && !stall;
  assign capture      = d_allow_in && f_to_d_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) d_valid_q <= 1'b0;
    else if (d_allow_in) d_valid_q <= f_to_d_valid;
  end

  // Latched instruction fields; flush drops the incoming instruction but leaves D_* untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      D_pc         <= '0;
      D_default_pc <= '0;
      D_imm        <= '0;
      D_instr      <= '0;
      D_opcode     <= '0;
      D_funct      <= '0;
      D_instr_type <= '0;
      D_rd         <= '0;
      D_rs1        <= '0;
      D_rs2        <= '0;
      D_commit     <= 1'b0;
    end else if (capture) begin
      D_pc         <= f_pc;
      D_default_pc <= f_default_pc;
      D_imm        <= f_imm;
      D_instr      <= f_instr;
      D_opcode     <= f_opcode;
      D_funct      <= f_funct;
      D_instr_type <= f_instr_type;
      D_rd         <= f_rd;
      D_rs1        <= f_rs1;
      D_rs2        <= f_rs2;
      D_commit     <= (f_pc >= COMMIT_BASE) && (f_pc <= COMMIT_LIMIT);
    end
  end

`ifdef DECODE_PERF_CNT_EN
  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (d_valid_q && stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (d_valid_q && flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_p.sv
// Self-checking bench for decode_stage_p: spec-level reference model plus directed literal checks.
module tb_decode_stage_p;
  import decode_stage_p_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, f_to_d_valid, e_allow_in;
  logic        d_allow_in, d_to_e_valid;
  logic [31:0] f_pc, f_default_pc, f_instr, f_imm;
  logic [6:0]  f_opcode;
  logic [9:0]  f_funct;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [2:0]  f_instr_type;
  logic        e_valid, e_wen, e_is_load, m_valid, m_wen, m_data_ok, w_valid, w_wen;
  logic [4:0]  e_rd, m_rd, w_rd;
  logic [31:0] e_data, m_data, w_data;
  logic [31:0] D_pc, D_default_pc, D_imm, D_instr, d_val1, d_val2;
  logic [6:0]  D_opcode;
  logic [9:0]  D_funct;
  logic [2:0]  D_instr_type;
  logic [4:0]  D_rd, D_rs1, D_rs2;
  logic        D_commit;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  decode_stage_p dut (
    .clk(clk), .rst(rst), .flush(flush), .f_to_d_valid(f_to_d_valid), .d_allow_in(d_allow_in),
    .e_allow_in(e_allow_in), .d_to_e_valid(d_to_e_valid), .f_pc(f_pc), .f_default_pc(f_default_pc),
    .f_instr(f_instr), .f_opcode(f_opcode), .f_funct(f_funct), .f_rd(f_rd), .f_rs1(f_rs1),
    .f_rs2(f_rs2), .f_imm(f_imm), .f_instr_type(f_instr_type), .e_valid(e_valid), .e_wen(e_wen),
    .e_is_load(e_is_load), .e_rd(e_rd), .e_data(e_data), .m_valid(m_valid), .m_wen(m_wen),
    .m_data_ok(m_data_ok), .m_rd(m_rd), .m_data(m_data), .w_valid(w_valid), .w_wen(w_wen),
    .w_rd(w_rd), .w_data(w_data), .D_pc(D_pc), .D_default_pc(D_default_pc), .D_imm(D_imm),
    .D_instr(D_instr), .D_opcode(D_opcode), .D_funct(D_funct), .D_instr_type(D_instr_type),
    .D_rd(D_rd), .D_rs1(D_rs1), .D_rs2(D_rs2), .D_commit(D_commit), .d_val1(d_val1), .d_val2(d_val2)
`ifdef DECODE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: one decode slot plus an array of architectural registers.
  bit          mv;
  logic [31:0] mpc, mdpc, mimm, minstr;
  logic [6:0]  mop;
  logic [9:0]  mfn;
  logic [2:0]  mty;
  logic [4:0]  mrd, mrs [2];
  bit          mcommit;
  logic [31:0] mrf [32];

  function automatic bit src_live(int k);
    bit used;
    if (k == 0) used = (mty == TYPER) || (mty == TYPEI) || (mty == TYPES) || (mty == TYPEB);
    else        used = (mty == TYPER) || (mty == TYPES) || (mty == TYPEB);
    return used && (mrs[k] != 5'd0);
  endfunction

  function automatic bit model_stall();
    for (int k = 0; k < 2; k++) begin
      if (src_live(k)) begin
        if (e_valid && e_wen && e_is_load && e_rd == mrs[k]) return 1'b1;
        if (m_valid && m_wen && !m_data_ok && m_rd == mrs[k]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Youngest ready producer wins; a load still in E cannot supply its data.
  function automatic logic [31:0] model_val(int k);
    bit          ok [3];
    logic [4:0]  rd [3];
    logic [31:0] dat [3];
    if (!src_live(k)) return 32'd0;
    ok[0] = e_valid && e_wen && !e_is_load; rd[0] = e_rd; dat[0] = e_data;
    ok[1] = m_valid && m_wen && m_data_ok;  rd[1] = m_rd; dat[1] = m_data;
    ok[2] = w_valid && w_wen;               rd[2] = w_rd; dat[2] = w_data;
    for (int i = 0; i < 3; i++) if (ok[i] && rd[i] == mrs[k]) return dat[i];
    return mrf[mrs[k]];
  endfunction

  function automatic bit model_allow();
    return !mv || (!model_stall() && e_allow_in);
  endfunction

  always @(posedge clk) begin
    bit allow;
    allow = model_allow();
    if (rst) begin
      mv = 0; mpc = 0; mdpc = 0; mimm = 0; minstr = 0; mop = 0; mfn = 0; mty = 0;
      mrd = 0; mrs[0] = 0; mrs[1] = 0; mcommit = 0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    end else begin
      if (allow && f_to_d_valid && !flush) begin
        mpc = f_pc; mdpc = f_default_pc; mimm = f_imm; minstr = f_instr; mop = f_opcode;
        mfn = f_funct; mty = f_instr_type; mrd = f_rd; mrs[0] = f_rs1; mrs[1] = f_rs2;
        mcommit = (f_pc >= 32'h80000000) && (f_pc <= 32'h87ffffff);
      end
      if (flush) mv = 0;
      else if (allow) mv = f_to_d_valid;
      if (w_valid && w_wen && w_rd != 5'd0) mrf[w_rd] = w_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_allow_in", 32'(d_allow_in), 32'(model_allow()));
      chk("m_to_e_valid", 32'(d_to_e_valid), 32'(mv && !model_stall()));
      chk("m_val1", d_val1, model_val(0));
      chk("m_val2", d_val2, model_val(1));
      chk("m_pc", D_pc, mpc);
      chk("m_default_pc", D_default_pc, mdpc);
      chk("m_imm", D_imm, mimm);
      chk("m_instr", D_instr, minstr);
      chk("m_opcode", 32'(D_opcode), 32'(mop));
      chk("m_funct", 32'(D_funct), 32'(mfn));
      chk("m_type", 32'(D_instr_type), 32'(mty));
      chk("m_rd", 32'(D_rd), 32'(mrd));
      chk("m_rs1", 32'(D_rs1), 32'(mrs[0]));
      chk("m_rs2", 32'(D_rs2), 32'(mrs[1]));
      chk("m_commit", 32'(D_commit), 32'(mcommit));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr, input logic [2:0] ty,
                         input logic [31:0] imm);
    f_to_d_valid = 1'b1;
    f_pc         = pc;
    f_default_pc = pc + 32'd4;
    f_instr      = instr;
    f_opcode     = instr[6:0];
    f_funct      = {instr[31:25], instr[14:12]};
    f_rd         = instr[11:7];
    f_rs1        = instr[19:15];
    f_rs2        = instr[24:20];
    f_imm        = imm;
    f_instr_type = ty;
  endtask

  task automatic set_e(input logic v, input logic ld, input logic [4:0] rd, input logic [31:0] d);
    e_valid = v; e_wen = v; e_is_load = ld; e_rd = rd; e_data = d;
  endtask

  task automatic set_m(input logic v, input logic ok, input logic [4:0] rd, input logic [31:0] d);
    m_valid = v; m_wen = v; m_data_ok = ok; m_rd = rd; m_data = d;
  endtask

  task automatic set_w(input logic v, input logic [4:0] rd, input logic [31:0] d);
    w_valid = v; w_wen = v; w_rd = rd; w_data = d;
  endtask

  logic [31:0] cpc [5];
  logic        cexp [5];

  initial begin
    rst = 1'b1; flush = 1'b0; e_allow_in = 1'b1;
    present(32'd0, 32'd0, TYPEU, 32'd0);
    f_to_d_valid = 1'b0;
    set_e(0, 0, 0, 0); set_m(0, 0, 0, 0); set_w(0, 0, 0);
    tick(); tick();
    rst = 1'b0; cmp_en = 1'b1;

    // addi x5,x0,7 at the commit base
    present(32'h80000000, 32'h00700293, TYPEI, 32'd7);
    @(negedge clk);
    chk("rst_to_e_valid", 32'(d_to_e_valid), 32'd0);
    chk("rst_pc", D_pc, 32'd0);
    chk("rst_allow_in", 32'(d_allow_in), 32'd1);
    tick(); f_to_d_valid = 1'b0;
    @(negedge clk);
    chk("addi_to_e_valid", 32'(d_to_e_valid), 32'd1);
    chk("addi_rs1", 32'(D_rs1), 32'd0);
    chk("addi_val1", d_val1, 32'd0);
    chk("addi_val2_unused", d_val2, 32'd0);
    chk("addi_commit", 32'(D_commit), 32'd1);

    // add x6,x5,x1 behind a load to x5
    tick();
    present(32'h80000004, 32'h00128333, TYPER, 32'd0);
    set_e(1, 1, 5'd5, 32'h99);
    tick();
    present(32'h80000008, 32'h003183b3, TYPER, 32'd0);
    @(negedge clk);
    chk("lu_to_e_valid", 32'(d_to_e_valid), 32'd0);
    chk("lu_allow_in", 32'(d_allow_in), 32'd0);
    tick();
    @(negedge clk);
    chk("lu_pc_hold", D_pc, 32'h80000004);
    tick();
    set_e(0, 0, 0, 0); set_m(1, 0, 5'd5, 32'hdeadbeef);
    @(negedge clk);
    chk("m_notok_to_e_valid", 32'(d_to_e_valid), 32'd0);
    tick();
    m_data_ok = 1'b1;
    @(negedge clk);
    chk("lu_fwd_val1", d_val1, 32'hdeadbeef);
    chk("lu_fwd_to_e_valid", 32'(d_to_e_valid), 32'd1);

    // add x7,x3,x3 with E/M/W all producing x3
    tick();
    f_to_d_valid = 1'b0; e_allow_in = 1'b0;
    set_e(1, 0, 5'd3, 32'd11); set_m(1, 1, 5'd3, 32'd22); set_w(1, 5'd3, 32'd33);
    @(negedge clk);
    chk("prio_e_val1", d_val1, 32'd11);
    chk("prio_e_val2", d_val2, 32'd11);
    tick(); set_e(0, 0, 0, 0);
    @(negedge clk);
    chk("prio_m_val1", d_val1, 32'd22);
    tick(); set_m(0, 0, 0, 0);
    @(negedge clk);
    chk("prio_w_val1", d_val1, 32'd33);
    tick(); set_w(0, 0, 0);
    @(negedge clk);
    chk("prio_rf_val2", d_val2, 32'd33);

    // add x8,x0,x0 while W and E target x0
    tick();
    e_allow_in = 1'b1;
    present(32'h8000000c, 32'h00000433, TYPER, 32'd0);
    set_w(1, 5'd0, 32'h1234); set_e(1, 0, 5'd0, 32'h5555);
    tick(); f_to_d_valid = 1'b0;
    @(negedge clk);
    chk("x0_val1", d_val1, 32'd0);
    chk("x0_val2", d_val2, 32'd0);
    tick(); set_w(0, 0, 0); set_e(0, 0, 0, 0);

    // flush while stalled, with a fetched instruction offered
    present(32'h80000010, 32'h00128333, TYPER, 32'd0);
    set_e(1, 1, 5'd5, 32'h0);
    tick();
    present(32'h80000014, 32'h00700293, TYPEI, 32'd7);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall_to_e_valid", 32'(d_to_e_valid), 32'd0);
    tick();
    flush = 1'b0; f_to_d_valid = 1'b0; set_e(0, 0, 0, 0);
    @(negedge clk);
    chk("fl_to_e_valid", 32'(d_to_e_valid), 32'd0);
    chk("fl_pc_hold", D_pc, 32'h80000010);
    chk("fl_allow_in", 32'(d_allow_in), 32'd1);

    // flush beats capture on an empty stage
    present(32'h80000018, 32'h00700293, TYPEI, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0; f_to_d_valid = 1'b0;
    @(negedge clk);
    chk("fl2_pc_hold", D_pc, 32'h80000010);
    chk("fl2_to_e_valid", 32'(d_to_e_valid), 32'd0);

    // commit window edges
    cpc[0] = 32'h7fffffff; cexp[0] = 1'b0;
    cpc[1] = 32'h80000000; cexp[1] = 1'b1;
    cpc[2] = 32'h87ffffff; cexp[2] = 1'b1;
    cpc[3] = 32'h88000000; cexp[3] = 1'b0;
    cpc[4] = 32'hffffffff; cexp[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      present(cpc[i], 32'h123452b7, TYPEU, 32'h12345000);
      tick();
      @(negedge clk);
      chk("commit_edge", 32'(D_commit), 32'(cexp[i]));
    end
    f_to_d_valid = 1'b0;
    tick();

`ifdef DECODE_PERF_CNT_EN
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("perf_rst_stall", stall_cnt, 32'd0);
    chk("perf_rst_flush", flush_cnt, 32'd0);
    present(32'h80000020, 32'h00128333, TYPER, 32'd0);
    set_e(1, 1, 5'd5, 32'h0);
    tick(); f_to_d_valid = 1'b0;
    tick(); tick(); tick();
    set_e(0, 0, 0, 0); flush = 1'b1;
    tick(); flush = 1'b0;
    @(negedge clk);
    chk("perf_stall_cnt", stall_cnt, 32'd3);
    chk("perf_flush_cnt", flush_cnt, 32'd1);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
